// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB register-bank completer.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;

  // Completer transfer state.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  // Reason a transfer gets an error response.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_RO    = 2'd3
  } apb_err_t;

endpackage

// File: rtl/apb_regbank.sv
// Register storage, word-index decode, error-cause generation and read mux.
// Register 0 is the read-only ID; registers 1..NUM_REGS-1 are read/write.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int                DATA_W   = APB_DATA_W,
  parameter int                ADDR_W   = APB_ADDR_W,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = APB_ID_VALUE
) (
  input  logic              apb_clk,
  input  logic              apb_reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  input  logic              commit,
  input  logic              rd_en,
  output apb_err_t          err_cause,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int RI_W  = $clog2(NUM_REGS);

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  assign idx      = addr[ADDR_W-1:2];
  assign in_range = int'(idx) < NUM_REGS;

  // Error cause of the latched access, alignment first, then range, then read-only.
  always_comb begin
    err_cause = ERR_NONE;
    if (addr[1:0] != 2'b00) begin
      err_cause = ERR_ALIGN;
    end else if (!in_range) begin
      err_cause = ERR_RANGE;
    end else if (write && (idx == '0)) begin
      err_cause = ERR_RO;
    end
  end

  // Read mux: data only for a legal read at completion time, zero otherwise.
  always_comb begin
    rdata = '0;
    if (rd_en && (err_cause == ERR_NONE)) begin
      if (idx == '0) begin
        rdata = ID_VALUE;
      end else begin
        rdata = regs[idx[RI_W-1:0]];
      end
    end
  end

  // One storage word per writable register, written only on a committed legal write.
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge apb_clk) begin
      if (apb_reset) begin
        regs[gi] <= '0;
      end else if (commit && (idx == IDX_W'(gi))) begin
        regs[gi] <= wdata;
      end
    end
  end

endmodule

// File: rtl/apb_regbank_completer.sv
// APB completer with a word-addressed register bank and programmable wait states.
// Optional macro APB_PROT_CHECK_EN enables a live-vs-latched protocol check with
// a sticky apb_prot_err flag; without it apb_prot_err is tied low.
module apb_regbank_completer
  import apb_pkg::*;
#(
  parameter int                DATA_W   = APB_DATA_W,
  parameter int                ADDR_W   = APB_ADDR_W,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = APB_ID_VALUE,
  parameter int                WAIT_W   = 8
) (
  input  logic              apb_clk,
  input  logic              apb_reset,
  input  logic              apb_selx,
  input  logic              apb_en,
  input  logic              apb_write,
  input  logic [ADDR_W-1:0] apb_addr,
  input  logic [DATA_W-1:0] apb_wdata,
  output logic [DATA_W-1:0] apb_rdata,
  output logic              apb_ready,
  output logic              apb_slverr,
  input  logic [WAIT_W-1:0] wait_cycle,
  output logic              apb_prot_err
);

  apb_state_t        state_reg, state_next;
  logic [WAIT_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              write_reg, write_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  apb_err_t err_cause;
  logic     xfer_err;
  logic     setup;
  logic     access_en;
  logic     prot_bad;
  logic     commit;
  logic     rd_en;

  // A setup phase (select without enable) starts or restarts a transfer in either state.
  assign setup     = apb_selx && !apb_en;
  assign access_en = (state_reg == ACCESS) && apb_selx && apb_en;
  assign apb_ready = (state_reg == ACCESS) && (cnt_reg == '0);
  assign xfer_err  = (err_cause != ERR_NONE);
  assign commit    = access_en && apb_ready && write_reg && !xfer_err && !prot_bad;
  assign rd_en     = apb_ready && !write_reg && !prot_bad;
  assign apb_slverr = apb_ready && (xfer_err || prot_bad);

`ifdef APB_PROT_CHECK_EN
  logic mis_now;
  logic mis_reg;
  logic en_seen_reg;
  logic en_fall;
  logic prot_err_reg;

  assign mis_now = access_en &&
                   ((apb_addr != addr_reg) || (apb_write != write_reg) ||
                    (write_reg && (apb_wdata != wdata_reg)));
  assign en_fall = (state_reg == ACCESS) && setup && en_seen_reg;
  assign prot_bad = mis_reg || mis_now;
  assign apb_prot_err = prot_err_reg;

  // Track per-transfer mismatches and raise the sticky protocol flag.
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      mis_reg      <= 1'b0;
      en_seen_reg  <= 1'b0;
      prot_err_reg <= 1'b0;
    end else begin
      if (setup) begin
        mis_reg     <= 1'b0;
        en_seen_reg <= 1'b0;
      end else begin
        if (mis_now) begin
          mis_reg <= 1'b1;
        end
        if (access_en) begin
          en_seen_reg <= 1'b1;
        end
      end
      if (mis_now || en_fall) begin
        prot_err_reg <= 1'b1;
      end
    end
  end
`else
  assign prot_bad     = 1'b0;
  assign apb_prot_err = 1'b0;
`endif

  // Next state, wait counter and setup latch.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    wdata_next = wdata_reg;
    if (setup) begin
      state_next = ACCESS;
      cnt_next   = wait_cycle;
      addr_next  = apb_addr;
      write_next = apb_write;
      wdata_next = apb_wdata;
    end else if (state_reg == ACCESS) begin
      if (!apb_selx) begin
        state_next = IDLE;
      end else if (apb_ready) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg - WAIT_W'(1);
      end
    end
  end

  // State and latch registers.
  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      wdata_reg <= wdata_next;
    end
  end

  apb_regbank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .apb_clk   (apb_clk),
    .apb_reset (apb_reset),
    .addr      (addr_reg),
    .write     (write_reg),
    .wdata     (wdata_reg),
    .commit    (commit),
    .rd_en     (rd_en),
    .err_cause (err_cause),
    .rdata     (apb_rdata)
  );

endmodule

// File: tb/tb_apb_regbank_completer.sv
// Self-checking bench for apb_regbank_completer: a transaction-level model
// predicts ready timing, error and read data; a negedge process compares.
module tb_apb_regbank_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        apb_clk = 1'b0;
  logic        apb_reset;
  logic        apb_selx;
  logic        apb_en;
  logic        apb_write;
  logic [7:0]  apb_addr;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_slverr;
  logic [7:0]  wait_cycle;
  logic        apb_prot_err;

  int total = 0;
  int bad   = 0;

  logic        chk_on = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_slverr = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        exp_prot = 1'b0;

  logic [31:0] mregs [16];

  always #5 apb_clk = ~apb_clk;

  apb_regbank_completer dut (
    .apb_clk      (apb_clk),
    .apb_reset    (apb_reset),
    .apb_selx     (apb_selx),
    .apb_en       (apb_en),
    .apb_write    (apb_write),
    .apb_addr     (apb_addr),
    .apb_wdata    (apb_wdata),
    .apb_rdata    (apb_rdata),
    .apb_ready    (apb_ready),
    .apb_slverr   (apb_slverr),
    .wait_cycle   (wait_cycle),
    .apb_prot_err (apb_prot_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model of one transfer outcome from the address map rules.
  task automatic model_resp(input logic w, input logic [7:0] a,
                            output logic err, output logic [31:0] rd);
    int idx;
    idx = int'(a[7:2]);
    err = (a[1:0] != 2'b00) || (idx >= 16) || (w && idx == 0);
    if (err || w)     rd = '0;
    else if (idx == 0) rd = ID;
    else               rd = mregs[idx];
  endtask

  // Cycle compare against the model's expectations.
  always @(negedge apb_clk) begin
    if (chk_on) begin
      chk("ready", {31'd0, apb_ready}, {31'd0, exp_ready});
      if (exp_ready) begin
        chk("slverr", {31'd0, apb_slverr}, {31'd0, exp_slverr});
        chk("rdata", apb_rdata, exp_rdata);
      end else begin
        chk("rdata_idle", apb_rdata, 32'd0);
      end
      chk("prot_err", {31'd0, apb_prot_err}, {31'd0, exp_prot});
    end
  end

  task automatic idle(input int n);
    apb_selx = 1'b0; apb_en = 1'b0; exp_ready = 1'b0;
    repeat (n) begin @(posedge apb_clk); #1; end
  endtask

  // Full transfer: setup then wt+1 access cycles; returns sampled response.
  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input int wt, output logic [31:0] got_rd, output logic got_err);
    logic        merr;
    logic [31:0] mrd;
    model_resp(w, a, merr, mrd);
    apb_selx = 1'b1; apb_en = 1'b0; apb_write = w; apb_addr = a; apb_wdata = d;
    wait_cycle = 8'(wt); exp_ready = 1'b0;
    @(posedge apb_clk); #1;
    wait_cycle = 8'(wt) ^ 8'h5A;
    got_rd = '0; got_err = 1'b0;
    for (int k = 1; k <= wt + 1; k++) begin
      apb_en = 1'b1;
      exp_ready  = (k == wt + 1);
      exp_slverr = merr;
      exp_rdata  = mrd;
      @(negedge apb_clk);
      if (k == wt + 1) begin got_rd = apb_rdata; got_err = apb_slverr; end
      @(posedge apb_clk); #1;
    end
    if (w && !merr) mregs[int'(a[7:2])] = d;
    apb_selx = 1'b0; apb_en = 1'b0; exp_ready = 1'b0;
    $display("xfer %s addr=%h wdata=%h wait=%0d rdata=%h slverr=%0b",
             w ? "WR" : "RD", a, d, wt, got_rd, got_err);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    foreach (mregs[i]) mregs[i] = '0;
    apb_reset = 1'b1; apb_selx = 1'b0; apb_en = 1'b0; apb_write = 1'b0;
    apb_addr = '0; apb_wdata = '0; wait_cycle = '0;
    repeat (2) @(posedge apb_clk);
    #1 chk_on = 1'b1;
    @(posedge apb_clk); #1;
    apb_reset = 1'b0;
    idle(1);

    // Zero-wait write then read.
    xfer(1'b1, 8'h04, 32'h0000_000A, 0, rd, er);
    chk("lit_wr04_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 8'h04, 32'h0, 0, rd, er);
    chk("lit_rd04", rd, 32'h0000_000A);
    idle(1);

    // Wait states on the ID register.
    xfer(1'b0, 8'h00, 32'h0, 3, rd, er);
    chk("lit_rd_id", rd, 32'hA9B0_0001);
    idle(1);

    // Error responses.
    xfer(1'b1, 8'h00, 32'hDEAD_BEEF, 0, rd, er);
    chk("lit_wr_ro_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h00, 32'h0, 1, rd, er);
    chk("lit_id_kept", rd, 32'hA9B0_0001);
    xfer(1'b0, 8'h06, 32'h0, 0, rd, er);
    chk("lit_misalign_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 8'h40, 32'h0, 2, rd, er);
    chk("lit_range_err", {31'd0, er}, 32'd1);
    xfer(1'b1, 8'h3C, 32'h1234_5678, 1, rd, er);
    xfer(1'b0, 8'h3C, 32'h0, 0, rd, er);
    chk("lit_rd_last", rd, 32'h1234_5678);
    idle(2);

    // Abort: initiator gives up after 20 access cycles.
    apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'h08;
    apb_wdata = 32'h5; wait_cycle = 8'd30; exp_ready = 1'b0;
    @(posedge apb_clk); #1;
    apb_en = 1'b1;
    repeat (20) begin @(posedge apb_clk); #1; end
    $display("xfer WR addr=08 wdata=00000005 wait=30 aborted");
    idle(2);
    xfer(1'b0, 8'h08, 32'h0, 0, rd, er);
    chk("lit_abort_rd08", rd, 32'h0);

    // Back-to-back writes and reads.
    xfer(1'b1, 8'h04, 32'h1, 0, rd, er);
    xfer(1'b1, 8'h08, 32'h2, 1, rd, er);
    xfer(1'b1, 8'h0C, 32'h3, 0, rd, er);
    xfer(1'b0, 8'h04, 32'h0, 0, rd, er);
    chk("lit_b2b_04", rd, 32'h1);
    xfer(1'b0, 8'h08, 32'h0, 2, rd, er);
    chk("lit_b2b_08", rd, 32'h2);
    xfer(1'b0, 8'h0C, 32'h0, 0, rd, er);
    chk("lit_b2b_0c", rd, 32'h3);
    idle(1);

`ifdef APB_PROT_CHECK_EN
    // Address changes mid-access: error, no write, sticky flag.
    apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'h04;
    apb_wdata = 32'h77; wait_cycle = 8'd2; exp_ready = 1'b0;
    @(posedge apb_clk); #1;
    apb_en = 1'b1;
    @(posedge apb_clk); #1;
    apb_addr = 8'h08;
    @(posedge apb_clk); #1;
    exp_prot = 1'b1; exp_ready = 1'b1; exp_slverr = 1'b1; exp_rdata = 32'h0;
    @(posedge apb_clk); #1;
    $display("xfer WR addr=04->08 wdata=00000077 wait=2 protocol violation");
    idle(1);
    xfer(1'b0, 8'h04, 32'h0, 0, rd, er);
    chk("lit_prot_04", rd, 32'h1);
    xfer(1'b0, 8'h08, 32'h0, 0, rd, er);
    chk("lit_prot_08", rd, 32'h2);
    idle(1);
`endif

    // Reset mid-transfer drops the write and clears the bank.
    apb_selx = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 8'h0C;
    apb_wdata = 32'h99; wait_cycle = 8'd3; exp_ready = 1'b0;
    @(posedge apb_clk); #1;
    apb_en = 1'b1;
    @(posedge apb_clk); #1;
    apb_reset = 1'b1; apb_selx = 1'b0; apb_en = 1'b0;
    @(posedge apb_clk); #1;
    exp_prot = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    $display("xfer WR addr=0c wdata=00000099 wait=3 reset mid-transfer");
    @(posedge apb_clk); #1;
    apb_reset = 1'b0;
    idle(1);
    xfer(1'b0, 8'h0C, 32'h0, 0, rd, er);
    chk("lit_rst_0c", rd, 32'h0);
    xfer(1'b0, 8'h04, 32'h0, 1, rd, er);
    chk("lit_rst_04", rd, 32'h0);
    idle(2);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
